i2s_frame_sequencer: RTL

I2S_FRAME_SEQUENCER -- requirements
Module: i2s_frame_sequencer

---
 rtl/i2s_frame_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/i2s_frame_sequencer.sv
// I2S transmitter: stereo-pair FIFO feeding a framed serial stream.
// Ports: clk/rst_n, enable, invert, s_valid/s_ready/s_left/s_right in;
// sd_out, ws, bck, underrun, level out. Optional I2S_UNDERRUN_HOLD_EN
// repeats the last popped pair on underrun instead of sending zeros.
module i2s_frame_sequencer #(
  parameter int DIV   = 26,
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     invert,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_left,
  input  logic [WIDTH-1:0]         s_right,
  output logic                     sd_out,
  output logic                     ws,
  output logic                     bck,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DIV);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]        div;
  logic [BW-1:0]        b;
  logic                 ch;
  logic [WIDTH-1:0]     shift;
  logic [WIDTH-1:0]     rword;
  logic [2*WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [2*WIDTH-1:0]   fifo_out;
  logic [2*WIDTH-1:0]   fill;
  logic [2*WIDTH-1:0]   load;

  logic tick, wrap, start, push, pop;

  assign tick = (div == DW'(DIV - 1));
  assign wrap = tick && (b == BW'(WIDTH - 1)) && ch;

  // A frame begins on leaving IDLE, or at the end of a right
  // slot while the stream is still requested.
  assign start = enable &&
                 ((state == IDLE) || wrap);

  assign s_ready  = (level != LW'(DEPTH));
  assign push     = s_valid && s_ready;
  assign pop      = start && (level != '0);
  assign fifo_out = mem[rp];
  assign load     = pop ? fifo_out : fill;

`ifdef I2S_UNDERRUN_HOLD_EN
  logic [2*WIDTH-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (pop) begin
      hold <= fifo_out;
    end
  end

  assign fill = hold;
`else
  assign fill = '0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = RUN;
      end
      RUN: begin
        if (wrap) state_nx = enable ? RUN : IDLE;
        else if (!enable) state_nx = STOP;
      end
      STOP: begin
        if (enable) state_nx = RUN;
        else if (wrap) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      b        <= '0;
      ch       <= 1'b0;
      shift    <= '0;
      rword    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= start && (level == '0);
      if (start) begin
        div   <= '0;
        b     <= '0;
        ch    <= 1'b0;
        shift <= load[2*WIDTH-1:WIDTH];
        rword <= load[WIDTH-1:0];
      end else if (state == IDLE || wrap) begin
        // idle, or last right bit done with no new frame
        div   <= '0;
        b     <= '0;
        ch    <= 1'b0;
        shift <= '0;
      end else if (tick) begin
        div <= '0;
        if (b == BW'(WIDTH - 1)) begin
          b     <= '0;
          ch    <= 1'b1;
          shift <= rword;
        end else begin
          b     <= b + BW'(1);
          shift <= shift << 1;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= {s_left, s_right};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  assign sd_out = shift[WIDTH-1];
  assign ws     = ch ^ invert;
  assign bck    = (div >= DW'(DIV / 2));

endmodule
